// File: rtl/compressor_mc_if.sv
// compressor_mc_if: sample and control bundle between the audio chain and
// compressor_mc.
//   in_valid/in          : one-cycle frame strobe and packed signed samples
//                          (channel k at [k*BITSIZE +: BITSIZE])
//   thr/ratio/attack/releas/linked/bypass : per-frame compressor controls
//   busy/out_valid/out   : frame-in-progress flag, result strobe, packed result
// The master drives the frame (I2S receiver side); the slave is the compressor.
interface compressor_mc_if #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2
);
  logic                         in_valid;
  logic [CHANNELS*BITSIZE-1:0]  in;
  logic [BITSIZE-1:0]           thr;
  logic [BITSIZE-1:0]           ratio;
  logic [BITSIZE-1:0]           attack;
  logic [BITSIZE-1:0]           releas;
  logic                         linked;
  logic                         bypass;
  logic                         busy;
  logic                         out_valid;
  logic [CHANNELS*BITSIZE-1:0]  out;

  modport master (
    output in_valid, in, thr, ratio, attack, releas, linked, bypass,
    input  busy, out_valid, out
  );

  modport slave (
    input  in_valid, in, thr, ratio, attack, releas, linked, bypass,
    output busy, out_valid, out
  );
endinterface

// File: rtl/compressor_mc.sv
// compressor_mc: multi-channel dynamic range compressor clocked on bclk.
// A captured frame of CHANNELS signed samples is processed channel by channel
// through one shared multiplier: LINK, then GAIN/MUL/SUM per channel, then all
// outputs update together with a one-cycle out_valid.
//   bclk  : processing clock
//   rst_n : asynchronous active-low reset
//   bus   : compressor_mc_if slave modport (frame in, controls, busy, result)
// Gains are unsigned Q1.(BITSIZE-1); FULL = 2^(BITSIZE-1)-1 is unity.
module compressor_mc #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2
) (
  input  logic           bclk,
  input  logic           rst_n,
  compressor_mc_if.slave bus
);

  localparam int W  = BITSIZE;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [W-1:0]  FULL   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MINV   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ONE    = W'(1);
  localparam logic [CW-1:0] CH_ONE = CW'(1);
  localparam logic [CW-1:0] LAST   = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LINK,
    ST_GAIN,
    ST_MUL,
    ST_SUM,
    ST_DONE
  } state_t;

  // |x|, with the most negative code mapped to FULL so it stays representable.
  function automatic logic [W-1:0] mag_f(input logic [W-1:0] x);
    if (x == MINV) begin
      return FULL;
    end else if (x[W-1]) begin
      return ~x + ONE;
    end else begin
      return x;
    end
  endfunction

  state_t                 state_r;
  logic [CW-1:0]          ch_r;
  logic [W-1:0]           x_r      [CHANNELS];
  logic [W-1:0]           res_r    [CHANNELS];
  logic [W-1:0]           gain_r   [CHANNELS];
  logic [W-1:0]           thr_r;
  logic [W-1:0]           ratio_r;
  logic [W-1:0]           attack_r;
  logic [W-1:0]           releas_r;
  logic                   linked_r;
  logic                   bypass_r;
  logic [W-1:0]           linkmag_r;
  logic [W-1:0]           g_cur_r;
  logic [2*W-1:0]         prod_r;
  logic [CHANNELS*W-1:0]  out_r;
  logic                   out_valid_r;
  logic                   busy_r;

  logic [W-1:0]   linkmax_s;
  logic [W-1:0]   cur_x_s;
  logic [W-1:0]   cur_mag_s;
  logic [W-1:0]   gain_old_s;
  logic           gain_upd_s;
  logic [W-1:0]   m_s;
  logic [W:0]     g_e_s;
  logic [W:0]     floor_e_s;
  logic [W:0]     rise_e_s;
  logic [W-1:0]   gain_calc_s;
  logic [W-1:0]   g_use_s;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] sum_s;
  logic [W-1:0]   r_s;
  logic [W-1:0]   res_s;

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;

  // Largest channel magnitude of the captured frame (shared-gain detector).
  always_comb begin
    linkmax_s = {W{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      if (mag_f(x_r[k]) > linkmax_s) begin
        linkmax_s = mag_f(x_r[k]);
      end else begin
        linkmax_s = linkmax_s;
      end
    end
  end

  // Gain tracking for the current channel; sums are one bit wider so they never wrap.
  always_comb begin
    cur_x_s    = x_r[ch_r];
    cur_mag_s  = mag_f(x_r[ch_r]);
    gain_old_s = linked_r ? gain_r[0] : gain_r[ch_r];
    // In linked mode only channel 0's slot moves the shared gain.
    gain_upd_s = !linked_r || (ch_r == {CW{1'b0}});
    m_s        = linked_r ? linkmag_r : cur_mag_s;
    g_e_s      = {1'b0, gain_old_s};
    floor_e_s  = {1'b0, ratio_r} + {1'b0, attack_r};
    rise_e_s   = {1'b0, gain_old_s} + {1'b0, releas_r};
    if (m_s > thr_r) begin
      if (g_e_s > floor_e_s) begin
        gain_calc_s = gain_old_s - attack_r;
      end else begin
        gain_calc_s = ratio_r;
      end
    end else if (m_s < thr_r) begin
      if (rise_e_s < {1'b0, FULL}) begin
        gain_calc_s = rise_e_s[W-1:0];
      end else begin
        gain_calc_s = FULL;
      end
    end else begin
      gain_calc_s = gain_old_s;
    end
    g_use_s = gain_upd_s ? gain_calc_s : gain_old_s;
  end

  // Shared multiplier and output reconstruction for the current channel.
  always_comb begin
    if (cur_mag_s > thr_r) begin
      prod_s = {{W{1'b0}}, cur_mag_s - thr_r} * {{W{1'b0}}, g_cur_r};
    end else begin
      prod_s = {(2*W){1'b0}};
    end
    sum_s = {{W{1'b0}}, thr_r} + (prod_r >> (W - 1));
    if (sum_s > {{W{1'b0}}, FULL}) begin
      r_s = FULL;
    end else begin
      r_s = sum_s[W-1:0];
    end
    if (bypass_r || (cur_mag_s <= thr_r)) begin
      res_s = cur_x_s;
    end else if (cur_x_s[W-1]) begin
      res_s = ~r_s + ONE;
    end else begin
      res_s = r_s;
    end
  end

  // Frame sequencer: capture, per-channel gain/multiply/sum, publish.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ch_r        <= {CW{1'b0}};
      thr_r       <= {W{1'b0}};
      ratio_r     <= {W{1'b0}};
      attack_r    <= {W{1'b0}};
      releas_r    <= {W{1'b0}};
      linked_r    <= 1'b0;
      bypass_r    <= 1'b0;
      linkmag_r   <= {W{1'b0}};
      g_cur_r     <= {W{1'b0}};
      prod_r      <= {(2*W){1'b0}};
      out_r       <= {(CHANNELS*W){1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        x_r[k]    <= {W{1'b0}};
        res_r[k]  <= {W{1'b0}};
        gain_r[k] <= FULL;
      end
    end else begin
      case (state_r)
        // DONE also accepts a new frame: busy is already low there.
        ST_IDLE, ST_DONE: begin
          out_valid_r <= 1'b0;
          if (bus.in_valid) begin
            for (int k = 0; k < CHANNELS; k++) begin
              x_r[k] <= bus.in[k*W +: W];
            end
            thr_r    <= bus.thr;
            ratio_r  <= (bus.ratio > FULL) ? FULL : bus.ratio;
            attack_r <= bus.attack;
            releas_r <= bus.releas;
            linked_r <= bus.linked;
            bypass_r <= bus.bypass;
            busy_r   <= 1'b1;
            state_r  <= ST_LINK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LINK: begin
          linkmag_r <= linkmax_s;
          ch_r      <= {CW{1'b0}};
          state_r   <= ST_GAIN;
        end
        ST_GAIN: begin
          if (gain_upd_s) begin
            gain_r[ch_r] <= gain_calc_s;
          end
          g_cur_r <= g_use_s;
          state_r <= ST_MUL;
        end
        ST_MUL: begin
          prod_r  <= prod_s;
          state_r <= ST_SUM;
        end
        ST_SUM: begin
          res_r[ch_r] <= res_s;
          if (ch_r == LAST) begin
            // Last channel's result goes straight to out alongside the stored ones.
            for (int k = 0; k < CHANNELS; k++) begin
              out_r[k*W +: W] <= (k == CHANNELS - 1) ? res_s : res_r[k];
            end
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            ch_r    <= ch_r + CH_ONE;
            state_r <= ST_GAIN;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compressor_mc.sv
// tb_compressor_mc: directed, table-driven bench for compressor_mc
// (BITSIZE=16, CHANNELS=2). Frames run in sequence, so gain state carries
// from one vector to the next; expected values are hand-computed.
module tb_compressor_mc;
  localparam int BITSIZE  = 16;
  localparam int CHANNELS = 2;

  localparam logic [15:0] T  = 16'h4000;
  localparam logic [15:0] R  = 16'h2000;
  localparam logic [15:0] A  = 16'h1000;
  localparam logic [15:0] L  = 16'h0100;
  localparam logic [15:0] Z  = 16'h0000;
  localparam logic [15:0] FF = 16'hFFFF;

  typedef struct {
    int          in0;
    int          in1;
    logic [15:0] thr;
    logic [15:0] ratio;
    logic [15:0] attack;
    logic [15:0] releas;
    logic        linked;
    logic        bypass;
    int          exp0;
    int          exp1;
  } vec_t;

  logic bclk  = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [29];

  compressor_mc_if #(.BITSIZE(BITSIZE), .CHANNELS(CHANNELS)) bus ();

  compressor_mc #(.BITSIZE(BITSIZE), .CHANNELS(CHANNELS)) dut (
    .bclk  (bclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 bclk = ~bclk;

  function automatic vec_t mk(int i0, int i1, logic [15:0] th, logic [15:0] ra,
                              logic [15:0] at, logic [15:0] re, logic lk, logic bp,
                              int e0, int e1);
    vec_t v;
    v.in0 = i0; v.in1 = i1; v.thr = th; v.ratio = ra; v.attack = at;
    v.releas = re; v.linked = lk; v.bypass = bp; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int out0();
    return int'($signed(bus.out[15:0]));
  endfunction

  function automatic int out1();
    return int'($signed(bus.out[31:16]));
  endfunction

  task automatic drive(input vec_t v);
    bus.in     = {16'(v.in1), 16'(v.in0)};
    bus.thr    = v.thr;
    bus.ratio  = v.ratio;
    bus.attack = v.attack;
    bus.releas = v.releas;
    bus.linked = v.linked;
    bus.bypass = v.bypass;
  endtask

  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  // Pulse in_valid, then follow cycles 1.. until out_valid (bounded).
  task automatic run_frame(input vec_t v, output int lat, output int busy_bad);
    drive(v);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = -1;
    busy_bad = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.out_valid) begin
        lat = n;
        if (bus.busy) busy_bad = 1;
        break;
      end
      if (!bus.busy) busy_bad = 1;
      step();
    end
  endtask

  initial begin
    int lat;
    int bb;
    int pulses;
    int first;
    int h0;
    int h1;
    vec_t v;

    // Passthrough, attack ramp, release, hold at threshold.
    vecs[0]  = mk(1000, -1000, T, R, A, L, 1'b0, 1'b0, 1000, -1000);
    vecs[1]  = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 28297, 0);
    vecs[2]  = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 26595, 0);
    vecs[3]  = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 24893, 0);
    vecs[4]  = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 23191, 0);
    vecs[5]  = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 21489, 0);
    vecs[6]  = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 19788, 0);
    vecs[7]  = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 19788, 0);
    vecs[8]  = mk(-30000, 0, T, R, A, L, 1'b0, 1'b0, -19788, 0);
    vecs[9]  = mk(1000, 0, T, R, A, L, 1'b0, 1'b0, 1000, 0);
    vecs[10] = mk(30000, 0, T, R, Z, L, 1'b0, 1'b0, 19894, 0);
    vecs[11] = mk(1000, 0, T, R, A, FF, 1'b0, 1'b0, 1000, 0);
    vecs[12] = mk(30000, 0, T, R, Z, L, 1'b0, 1'b0, 29999, 0);
    vecs[13] = mk(30000, 0, T, R, A, L, 1'b0, 1'b0, 28297, 0);
    vecs[14] = mk(16384, 0, T, R, A, L, 1'b0, 1'b0, 16384, 0);
    vecs[15] = mk(30000, 0, T, R, Z, L, 1'b0, 1'b0, 28297, 0);
    // Edges: most negative input, bypass, ratio above FULL.
    vecs[16] = mk(1000, -32768, T, R, Z, L, 1'b0, 1'b0, 1000, -32766);
    vecs[17] = mk(30000, -30000, T, R, A, L, 1'b0, 1'b1, 30000, -30000);
    vecs[18] = mk(30000, -30000, T, R, Z, L, 1'b0, 1'b0, 26701, -28297);
    vecs[19] = mk(30000, 30000, T, FF, A, L, 1'b0, 1'b0, 29999, 29999);
    vecs[20] = mk(30000, 30000, T, FF, A, L, 1'b0, 1'b0, 29999, 29999);
    // Linked ramp, then the same stimulus unlinked, then max detection on ch1.
    vecs[21] = mk(30000, 20000, T, R, A, L, 1'b1, 1'b0, 28297, 19547);
    vecs[22] = mk(30000, 20000, T, R, A, L, 1'b1, 1'b0, 26595, 19095);
    vecs[23] = mk(30000, 20000, T, R, A, L, 1'b1, 1'b0, 24893, 18643);
    vecs[24] = mk(30000, 20000, T, R, A, L, 1'b1, 1'b0, 23191, 18191);
    vecs[25] = mk(30000, 20000, T, R, A, L, 1'b1, 1'b0, 21489, 17739);
    vecs[26] = mk(30000, 20000, T, R, A, L, 1'b1, 1'b0, 19788, 17288);
    vecs[27] = mk(30000, 20000, T, R, A, L, 1'b0, 1'b0, 19788, 19547);
    vecs[28] = mk(1000, 30000, T, R, Z, L, 1'b1, 1'b0, 1000, 19788);

    bus.in_valid = 1'b0;
    drive(vecs[0]);

    // Reset state.
    step();
    step();
    chk("reset out", int'(bus.out), 0);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 29; i++) begin
      run_frame(vecs[i], lat, bb);
      chk($sformatf("v%0d latency", i), lat, 8);
      chk($sformatf("v%0d busy window", i), bb, 0);
      chk($sformatf("v%0d out0", i), out0(), vecs[i].exp0);
      chk($sformatf("v%0d out1", i), out1(), vecs[i].exp1);
      h0 = out0();
      h1 = out1();
      step();
      chk($sformatf("v%0d out_valid drop", i), int'(bus.out_valid), 0);
      chk($sformatf("v%0d out hold", i), out0() + out1(), h0 + h1);
    end

    // in_valid during a frame is ignored: exactly one out_valid at cycle 8.
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    step();
    pulses = 0;
    first = -1;
    for (int n = 1; n <= 16; n++) begin
      bus.in_valid = (n == 3);
      if (bus.out_valid) begin
        pulses++;
        if (first < 0) first = n;
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("midframe pulse count", pulses, 1);
    chk("midframe latency", first, 8);
    chk("midframe out0", out0(), 1000);
    chk("midframe out1", out1(), -1000);

    // Reset at cycle 4 aborts the frame and restores unity gains.
    v = mk(30000, 20000, T, R, A, L, 1'b0, 1'b0, 28297, 19547);
    drive(v);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort busy", int'(bus.busy), 0);
    chk("abort out_valid", int'(bus.out_valid), 0);
    chk("abort out", int'(bus.out), 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      if (bus.out_valid) pulses++;
      step();
    end
    chk("abort no out_valid", pulses, 0);
    run_frame(vecs[0], lat, bb);
    chk("fresh latency", lat, 8);
    chk("fresh busy window", bb, 0);
    chk("fresh out0", out0(), 1000);
    chk("fresh out1", out1(), -1000);
    step();
    run_frame(v, lat, bb);
    chk("fresh attack latency", lat, 8);
    chk("fresh attack out0", out0(), v.exp0);
    chk("fresh attack out1", out1(), v.exp1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
